// File: rtl/arbitro_compuerta_if.sv
// Lane sensor/keypad inputs and gate/lamp outputs of the shared parking gate.
// master drives the lanes (bench or lane front-end); slave is the arbiter.
interface arbitro_compuerta_if;
    logic       Vehiculo0;
    logic       Vehiculo1;
    logic       enterPin0;
    logic       enterPin1;
    logic [7:0] Pin0;
    logic [7:0] Pin1;
    logic       Termino;
    logic [1:0] Grant;
    logic       Abierto;
    logic       Cerrado;
    logic       Alarma;
    logic       Bloqueo;
    logic       Ocupado;

    modport master (
        output Vehiculo0, Vehiculo1, enterPin0, enterPin1, Pin0, Pin1, Termino,
        input  Grant, Abierto, Cerrado, Alarma, Bloqueo, Ocupado
    );

    modport slave (
        input  Vehiculo0, Vehiculo1, enterPin0, enterPin1, Pin0, Pin1, Termino,
        output Grant, Abierto, Cerrado, Alarma, Bloqueo, Ocupado
    );
endinterface

// File: rtl/arbitro_compuerta.sv
// Two-lane parking gate arbiter: round-robin grant, PIN check, open/close with timeout and tailgate lockout.
// Outputs are Moore decodes of registered state; a sampled input shows on the outputs one cycle later.
module arbitro_compuerta #(
    parameter logic [7:0] PIN_CORRECTO = 8'h5A,
    parameter int         MAX_INTENTOS = 3,
    parameter int         TIMEOUT      = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    arbitro_compuerta_if.slave  bus
);
    localparam int FW = ($clog2(MAX_INTENTOS + 1) < 2) ? 2 : $clog2(MAX_INTENTOS + 1);
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_INTENTOS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_ESPERA_PIN = 2'd1;
    localparam logic [1:0] S_ABIERTO    = 2'd2;
    localparam logic [1:0] S_BLOQUEO    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q,  last_d;
    logic [FW-1:0] fail_q,  fail_d;
    logic [TW-1:0] tmo_q,   tmo_d;

    // Per-lane correct-PIN strobes, plus a view of whichever lane holds the gate.
    logic       pin_ok0, pin_ok1;
    logic       veh_g, strobe_g;
    logic [7:0] pin_g;

    assign pin_ok0  = bus.enterPin0 && (bus.Pin0 == PIN_CORRECTO);
    assign pin_ok1  = bus.enterPin1 && (bus.Pin1 == PIN_CORRECTO);
    assign veh_g    = grant_q[1] ? bus.Vehiculo1 : bus.Vehiculo0;
    assign strobe_g = grant_q[1] ? bus.enterPin1 : bus.enterPin0;
    assign pin_g    = grant_q[1] ? bus.Pin1      : bus.Pin0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        fail_d  = fail_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.Vehiculo0 && bus.Vehiculo1) begin
                    grant_d = last_q ? 2'b01 : 2'b10;
                    state_d = S_ESPERA_PIN;
                end else if (bus.Vehiculo0) begin
                    grant_d = 2'b01;
                    state_d = S_ESPERA_PIN;
                end else if (bus.Vehiculo1) begin
                    grant_d = 2'b10;
                    state_d = S_ESPERA_PIN;
                end
            end

            S_ESPERA_PIN: begin
                // A vehicle leaving wins over a PIN typed in the same cycle.
                if (!veh_g) begin
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end else if (strobe_g) begin
                    if (pin_g == PIN_CORRECTO) begin
                        fail_d  = '0;
                        tmo_d   = '0;
                        state_d = S_ABIERTO;
                    end else if (fail_q < FAIL_MAX) begin
                        fail_d = fail_q + FW'(1);
                    end
                end
            end

            S_ABIERTO: begin
                tmo_d = tmo_q + TW'(1);
                if (bus.Termino) begin
                    grant_d = 2'b00;
                    if (veh_g) begin
                        state_d = S_BLOQUEO;
                    end else begin
                        last_d  = grant_q[1];
                        state_d = S_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    grant_d = 2'b00;
                    state_d = S_BLOQUEO;
                end
            end

            S_BLOQUEO: begin
                grant_d = 2'b00;
                if (pin_ok0 || pin_ok1) begin
                    fail_d  = '0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            fail_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.Grant   = grant_q;
    assign bus.Ocupado = grant_q[0] | grant_q[1];
    assign bus.Abierto = (state_q == S_ABIERTO);
    assign bus.Cerrado = (state_q != S_ABIERTO);
    assign bus.Bloqueo = (state_q == S_BLOQUEO);
    // Alarm survives a lane withdrawing; only a correct PIN clears the fail count.
    assign bus.Alarma  = (state_q == S_BLOQUEO) || (fail_q >= FAIL_MAX);

    a_grant_onehot: assert property (@(posedge Clk) disable iff (Reset) grant_q != 2'b11);
    a_gate_excl:    assert property (@(posedge Clk) disable iff (Reset) bus.Abierto != bus.Cerrado);
    a_lock_nogrant: assert property (@(posedge Clk) disable iff (Reset)
                                     (state_q == S_BLOQUEO) |-> (grant_q == 2'b00));
endmodule

// File: tb/tb_arbitro_compuerta.sv
// Directed bench for the two-lane gate arbiter; status packed as {Grant, Abierto, Cerrado, Alarma, Bloqueo, Ocupado}.
module tb_arbitro_compuerta;
    logic Clk;
    logic Reset;
    int   n_vec;
    int   n_err;

    arbitro_compuerta_if bus ();

    arbitro_compuerta #(
        .PIN_CORRECTO (8'h5A),
        .MAX_INTENTOS (3),
        .TIMEOUT      (16)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    localparam logic [6:0] ST_IDLE   = 7'b00_0_1_0_0_0;
    localparam logic [6:0] ST_IDLE_A = 7'b00_0_1_1_0_0;
    localparam logic [6:0] ST_W0     = 7'b01_0_1_0_0_1;
    localparam logic [6:0] ST_W0_A   = 7'b01_0_1_1_0_1;
    localparam logic [6:0] ST_W1     = 7'b10_0_1_0_0_1;
    localparam logic [6:0] ST_W1_A   = 7'b10_0_1_1_0_1;
    localparam logic [6:0] ST_O0     = 7'b01_1_0_0_0_1;
    localparam logic [6:0] ST_O1     = 7'b10_1_0_0_0_1;
    localparam logic [6:0] ST_LOCK   = 7'b00_0_1_1_1_0;

    function automatic logic [6:0] status();
        return {bus.Grant, bus.Abierto, bus.Cerrado, bus.Alarma, bus.Bloqueo, bus.Ocupado};
    endfunction

    task automatic chk_vec(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pin0(input logic [7:0] p);
        bus.enterPin0 = 1'b1;
        bus.Pin0      = p;
        tick();
        bus.enterPin0 = 1'b0;
    endtask

    task automatic pin1(input logic [7:0] p);
        bus.enterPin1 = 1'b1;
        bus.Pin1      = p;
        tick();
        bus.enterPin1 = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        Reset = 1'b0;
        bus.Vehiculo0 = 1'b0;
        bus.Vehiculo1 = 1'b0;
        bus.enterPin0 = 1'b0;
        bus.enterPin1 = 1'b0;
        bus.Pin0      = 8'h00;
        bus.Pin1      = 8'h00;
        bus.Termino   = 1'b0;

        #2 Reset = 1'b1;
        #1 chk_vec("reset", status(), ST_IDLE);
        tick();
        Reset = 1'b0;

        // PIN strobes with no vehicle are ignored in IDLE
        pin0(8'h5A);
        chk_vec("idle_pin_ignored", status(), ST_IDLE);

        // both lanes waiting: lane 0 wins the first tie
        bus.Vehiculo0 = 1'b1;
        bus.Vehiculo1 = 1'b1;
        tick();
        chk_vec("rr_first", status(), ST_W0);
        pin0(8'h5A);
        chk_vec("open0", status(), ST_O0);
        bus.Vehiculo0 = 1'b0;
        bus.Termino   = 1'b1;
        tick();
        bus.Termino   = 1'b0;
        chk_vec("close0", status(), ST_IDLE);

        // both waiting again: lane 1 wins since lane 0 was last served
        bus.Vehiculo0 = 1'b1;
        tick();
        chk_vec("rr_second", status(), ST_W1);

        pin1(8'h00);
        chk_vec("wrong1", status(), ST_W1);
        pin1(8'h00);
        chk_vec("wrong2", status(), ST_W1);
        pin1(8'h00);
        chk_vec("wrong3_alarm", status(), ST_W1_A);
        pin0(8'h5A);
        chk_vec("other_lane_ignored", status(), ST_W1_A);
        pin1(8'h00);
        chk_vec("wrong4_sat", status(), ST_W1_A);
        pin1(8'h5A);
        chk_vec("open1_clear", status(), ST_O1);

        bus.Vehiculo1 = 1'b0;
        bus.Termino   = 1'b1;
        tick();
        bus.Termino   = 1'b0;
        chk_vec("close1", status(), ST_IDLE);

        // tailgating: Termino while the granted vehicle is still present
        tick();
        chk_vec("grant0_again", status(), ST_W0);
        pin0(8'h5A);
        chk_vec("open0_b", status(), ST_O0);
        bus.Termino = 1'b1;
        tick();
        bus.Termino = 1'b0;
        chk_vec("tailgate_lock", status(), ST_LOCK);
        pin0(8'h11);
        chk_vec("lock_wrong_pin", status(), ST_LOCK);
        bus.Termino = 1'b1;
        tick();
        bus.Termino = 1'b0;
        chk_vec("lock_ignores_inputs", status(), ST_LOCK);
        pin1(8'h5A);
        chk_vec("unlock1", status(), ST_IDLE);

        // open-gate timeout
        tick();
        chk_vec("grant0_tmo", status(), ST_W0);
        pin0(8'h5A);
        chk_vec("open0_tmo", status(), ST_O0);
        for (int i = 0; i < 15; i++) tick();
        chk_vec("tmo_15_open", status(), ST_O0);
        tick();
        chk_vec("tmo_16_lock", status(), ST_LOCK);

        // both strobes, only lane 0 correct
        bus.enterPin0 = 1'b1;
        bus.Pin0      = 8'h5A;
        bus.enterPin1 = 1'b1;
        bus.Pin1      = 8'h33;
        tick();
        bus.enterPin0 = 1'b0;
        bus.enterPin1 = 1'b0;
        chk_vec("unlock_both", status(), ST_IDLE);

        // asynchronous reset in the middle of an open gate
        tick();
        chk_vec("grant0_rst", status(), ST_W0);
        pin0(8'h5A);
        tick();
        chk_vec("open0_rst", status(), ST_O0);
        bus.Vehiculo0 = 1'b0;
        #2 Reset = 1'b1;
        #1 chk_vec("reset_mid_open", status(), ST_IDLE);
        tick();
        Reset = 1'b0;

        // lane withdrawal keeps the fail count and alarm
        bus.Vehiculo1 = 1'b1;
        tick();
        chk_vec("grant1_solo", status(), ST_W1);
        pin1(8'h01);
        pin1(8'h02);
        pin1(8'h03);
        chk_vec("alarm1_again", status(), ST_W1_A);
        bus.Vehiculo1 = 1'b0;
        tick();
        chk_vec("withdraw_keeps_alarm", status(), ST_IDLE_A);
        bus.Vehiculo0 = 1'b1;
        tick();
        chk_vec("regrant_alarm", status(), ST_W0_A);
        pin0(8'h5A);
        chk_vec("open_clears_alarm", status(), ST_O0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
